// File: rtl/alu_pkg.sv
// Shared operation encodings and FSM state type for the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OpAnd = 3'b000,
        OpOr  = 3'b001,
        OpAdd = 3'b010,
        OpSub = 3'b011,
        OpSlt = 3'b100,
        OpNor = 3'b101,
        OpMul = 3'b110,
        OpDiv = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMul  = 2'b01,
        StDiv  = 2'b10,
        StDone = 2'b11
    } state_e;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
module alu_iter_unit import alu_pkg::*; #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next,
    output logic             dbz
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    // hi: product high half / partial remainder; lo: multiplier / dividend-quotient
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             div_q, div_d, dbz_q, dbz_d;
    logic [WIDTH:0]   acc, shifted, trial;

    // Next-state for load and per-step iteration
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        dbz_d   = dbz_q;
        acc     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        trial   = shifted - {1'b0, opnd_q};
        if (load) begin
            cnt_d = '0;
            div_d = is_div;
            dbz_d = is_div && (b == '0);
            if (is_div && (b == '0)) begin
                // Divide by zero: final answer is known, iterations just burn time
                hi_d   = a;
                lo_d   = '1;
                opnd_d = b;
            end else if (is_div) begin
                hi_d   = '0;
                lo_d   = a;
                opnd_d = b;
            end else begin
                hi_d   = '0;
                lo_d   = b;
                opnd_d = a;
            end
        end else if (step) begin
            cnt_d = cnt_q + CntW'(1);
            if (dbz_q) begin
                hi_d = hi_q;
            end else if (div_q) begin
                if (!trial[WIDTH]) begin
                    hi_d = trial[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                {hi_d, lo_d} = {acc, lo_q[WIDTH-1:1]};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            div_q  <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            dbz_q  <= dbz_d;
        end
    end

    assign last    = (cnt_q == CntW'(WIDTH - 1));
    assign lo_next = lo_d;
    assign hi_next = hi_d;
    assign dbz     = dbz_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative MUL/DIV via alu_iter_unit.
module alu_seq import alu_pkg::*; #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             div_by_zero
);

    state_e           state_q, state_d;
    op_e              op_s;
    logic             load, step, last, iter_dbz, cap_alu, cap_iter;
    logic [WIDTH-1:0] lo_next, hi_next, b_eff, alu_res;
    logic [WIDTH:0]   sum;
    logic             sub_en, ovf_as, alu_carry, alu_ovf;

    assign op_s = op_e'(op);

    // FSM next state and iteration control
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        cap_alu = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (op_s == OpMul) begin
                        state_d = StMul;
                        load    = 1'b1;
                    end else if (op_s == OpDiv) begin
                        state_d = StDiv;
                        load    = 1'b1;
                    end else begin
                        state_d = StDone;
                        cap_alu = 1'b1;
                    end
                end
            end
            StMul, StDiv: begin
                if (last) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign step     = (state_q == StMul) || (state_q == StDiv);
    assign cap_iter = step && last;
    assign busy     = step;
    assign done     = (state_q == StDone);

    // Single-cycle ALU; ADD/SUB/SLT share one WIDTH+1 adder
    always_comb begin
        sub_en    = (op_s == OpSub) || (op_s == OpSlt);
        b_eff     = sub_en ? ~b : b;
        sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_en};
        // Carry into MSB recovered from the MSB sum bit
        ovf_as    = (a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (op_s)
            OpAnd: alu_res = a & b;
            OpOr:  alu_res = a | b;
            OpNor: alu_res = ~(a | b);
            OpAdd, OpSub: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = ovf_as;
            end
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_as};
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Result and flag registers, updated only when an operation completes
    always_ff @(posedge clk) begin
        if (reset) begin
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            carry       <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (cap_alu) begin
            result      <= alu_res;
            result_hi   <= '0;
            zero        <= (alu_res == '0);
            carry       <= alu_carry;
            overflow    <= alu_ovf;
            div_by_zero <= 1'b0;
        end else if (cap_iter) begin
            result      <= lo_next;
            result_hi   <= hi_next;
            zero        <= (lo_next == '0);
            carry       <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= iter_dbz && (state_q == StDiv);
        end
    end

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .is_div  (op_s == OpDiv),
        .step    (step),
        .a       (a),
        .b       (b),
        .last    (last),
        .lo_next (lo_next),
        .hi_next (hi_next),
        .dbz     (iter_dbz)
    );

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits, legal range 4..64.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe, accepted only when busy=0.
REQ-005 op  input  3  operation select, sampled on accepted start.
REQ-006 a  input  WIDTH  operand A, sampled on accepted start.
REQ-007 b  input  WIDTH  operand B, sampled on accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid result/flags.
REQ-010 result  output  WIDTH  primary result: low product for MUL, quotient for DIV.
REQ-011 result_hi  output  WIDTH  high product for MUL, remainder for DIV, zero for all other ops.
REQ-012 zero, carry, overflow, div_by_zero  output  1 each  registered status flags.

Function
REQ-013 op encoding SHALL be 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT (signed), 101 NOR, 110 MUL (unsigned), 111 DIV (unsigned).
REQ-014 The FSM SHALL have states IDLE, MUL, DIV, DONE.
REQ-015 IDLE + start with op 000..101 -> DONE; result and flags SHALL be registered on the accept edge; done=1 the next cycle (latency 1).
REQ-016 IDLE + start with op 110 -> MUL, op 111 -> DIV; busy=1 from the cycle after accept.
REQ-017 MUL SHALL be shift-add, one partial product per cycle, exactly WIDTH iterations, then DONE; done asserts WIDTH+1 cycles after accept.
REQ-018 DIV SHALL be restoring division, one quotient bit per cycle, exactly WIDTH iterations, then DONE; same latency as MUL.
REQ-019 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE; a start in that cycle is not accepted.
REQ-020 start while busy=1 or in DONE SHALL be ignored; operands are not resampled.
REQ-021 result, result_hi and flags SHALL hold their values until the next done.
REQ-022 ADD/SUB SHALL compute a + b and a + ~b + 1 in WIDTH+1 bits; carry = bit WIDTH (SUB: carry=1 iff a >= b unsigned).
REQ-023 overflow SHALL equal carry into MSB XOR carry out of MSB for ADD/SUB; 0 for all other ops.
REQ-024 SLT SHALL give result=1 iff a < b signed, else 0, with overflow handled correctly.
REQ-025 zero SHALL be 1 iff result == 0 (result_hi excluded).
REQ-026 carry SHALL be 0 for AND, OR, NOR, SLT, MUL, DIV.
REQ-027 DIV with b=0 SHALL skip iteration: result all ones, result_hi=a, div_by_zero=1, done after exactly WIDTH+1 cycles (fixed latency).
REQ-028 div_by_zero SHALL be 0 for every other completed operation.

Reset
REQ-029 reset SHALL force IDLE, busy=0, done=0, result=0, result_hi=0, all flags 0 on the next edge.
REQ-030 reset during MUL/DIV SHALL abort; no done pulse for the aborted operation.
REQ-031 reset has priority over start in the same cycle.

Structure
REQ-032 Shared package alu_pkg SHALL hold op encodings and the FSM state enum.
REQ-033 The iterative MUL/DIV datapath (accumulator, shift registers, iteration counter of clog2(WIDTH)+1 bits) SHALL be the sub-module alu_iter_unit; single-cycle ops stay in alu_seq.

Verification (WIDTH=16)
REQ-034 ADD a=0x7FFF b=0x0001 -> done 1 cycle after accept, result=0x8000, overflow=1, carry=0, zero=0.
REQ-035 SUB a=0x0005 b=0x0005 -> result=0x0000, zero=1, carry=1, overflow=0; SLT a=0xFFFF b=0x0001 -> result=0x0001.
REQ-036 MUL a=0x0100 b=0x0100 -> done 17 cycles after accept, result=0x0000, result_hi=0x0001, zero=1; busy high cycles 1..16.
REQ-037 DIV a=100 b=7 -> done at cycle 17, result=14, result_hi=2; DIV a=0x1234 b=0 -> result=0xFFFF, result_hi=0x1234, div_by_zero=1.
REQ-038 MUL started, reset at cycle 5 -> busy=0 next cycle, no done, outputs 0; new ADD then completes normally.
REQ-039 start pulsed with new op/operands during DIV and in the DONE cycle -> ignored, original quotient reported, exactly one done.
